// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule: a single round-key generator is reused for rounds 1..10.
// The eleven round keys stay in registers and can be read back through rd_addr.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] sq, inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse is a^254, built as a^2 * a^4 * ... * a^128; zero maps to zero
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_generation (
  input  logic [3:0]   rc,
  input  logic [127:0] in_key,
  output logic [127:0] out_key
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] rot_w, sub_w;
  logic [7:0]  rcon;
  logic [31:0] t, o0, o1, o2, o3;

  assign rot_w = {in_key[23:0], in_key[31:24]};

  aes_sbox u_sbox [NUM_LANES-1:0] (.a(rot_w), .s(sub_w));

  always_comb begin
    rcon = 8'h00;
    case (rc)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub_w ^ {rcon, 24'h000000};
  assign o0 = in_key[127:96] ^ t;
  assign o1 = in_key[95:64]  ^ o0;
  assign o2 = in_key[63:32]  ^ o1;
  assign o3 = in_key[31:0]   ^ o2;
  assign out_key = {o0, o1, o2, o3};
endmodule

module key_schedule_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state;
  logic [3:0]   rc;
  logic [127:0] rk [0:10];
  logic [127:0] kg_out;

  key_generation u_keygen (
    .rc      (rc),
    .in_key  (rk[rc - 4'd1]),
    .out_key (kg_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rc         <= 4'd1;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (key_valid) begin
            rk[0]      <= key_in;
            rc         <= 4'd1;
            keys_valid <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk[rc] <= kg_out;
          if (rc == 4'd10) begin
            // rc parks at 1 so it never leaves 1..10
            rc         <= 4'd1;
            keys_valid <= 1'b1;
            done       <= 1'b1;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= READY;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'd10) rd_key = rk[rd_addr];
  end
endmodule
